// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and derived frame geometry shared by
// the scanout datapath and its timing generator.
package vga_timing_pkg;

  localparam int unsigned DEF_HVIS    = 640;
  localparam int unsigned DEF_HFP     = 16;
  localparam int unsigned DEF_HSYNC   = 96;
  localparam int unsigned DEF_HBP     = 48;
  localparam int unsigned DEF_VVIS    = 480;
  localparam int unsigned DEF_VFP     = 10;
  localparam int unsigned DEF_VSYNC   = 2;
  localparam int unsigned DEF_VBP     = 33;

  localparam int unsigned DEF_HT      = DEF_HVIS + DEF_HFP + DEF_HSYNC + DEF_HBP;
  localparam int unsigned DEF_VT      = DEF_VVIS + DEF_VFP + DEF_VSYNC + DEF_VBP;

  localparam int unsigned DEF_DWIDTH  = 16;
  localparam int unsigned DEF_AWIDTH  = 15;
  localparam int unsigned DEF_COLOR_W = 8;

  localparam int unsigned WPL         = DEF_HVIS / DEF_DWIDTH;

  function automatic int unsigned words_per_line(input int unsigned hvis,
                                                 input int unsigned dwidth);
    return hvis / dwidth;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical counters with undelayed sync, visible-area and
// frame-start decode.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned HVIS  = DEF_HVIS,
  parameter int unsigned HFP   = DEF_HFP,
  parameter int unsigned HSYNC = DEF_HSYNC,
  parameter int unsigned HBP   = DEF_HBP,
  parameter int unsigned VVIS  = DEF_VVIS,
  parameter int unsigned VFP   = DEF_VFP,
  parameter int unsigned VSYNC = DEF_VSYNC,
  parameter int unsigned VBP   = DEF_VBP,
  localparam int unsigned HT   = HVIS + HFP + HSYNC + HBP,
  localparam int unsigned VT   = VVIS + VFP + VSYNC + VBP,
  localparam int unsigned HW   = $clog2(HT),
  localparam int unsigned VW   = $clog2(VT)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          vis_o,
  output logic          frame_start_o
);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hold_q;

  // Counters park at (0,0) for every clock that follows a reset edge, so the
  // first clock after the first non-reset edge is a clean frame start.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!hold_q) begin
      if (h_q == HW'(HT - 1)) begin
        h_d = '0;
        v_d = (v_q == VW'(VT - 1)) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      h_q    <= '0;
      v_q    <= '0;
      hold_q <= 1'b1;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      hold_q <= 1'b0;
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign hsync_o       = !hold_q && (h_q >= HW'(HVIS + HFP)) && (h_q < HW'(HVIS + HFP + HSYNC));
  assign vsync_o       = !hold_q && (v_q >= VW'(VVIS + VFP)) && (v_q < VW'(VVIS + VFP + VSYNC));
  assign vis_o         = !hold_q && (h_q < HW'(HVIS)) && (v_q < VW'(VVIS));
  assign frame_start_o = !hold_q && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// Read-side video RAM master: fetches 1bpp words, serialises them MSB-first
// and emits pixel/sync/blank two clocks behind the timing counters.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int unsigned DWIDTH    = DEF_DWIDTH,
  parameter int unsigned AWIDTH    = DEF_AWIDTH,
  parameter int unsigned COLOR_W   = DEF_COLOR_W,
  parameter int unsigned HVIS      = DEF_HVIS,
  parameter int unsigned HFP       = DEF_HFP,
  parameter int unsigned HSYNC     = DEF_HSYNC,
  parameter int unsigned HBP       = DEF_HBP,
  parameter int unsigned VVIS      = DEF_VVIS,
  parameter int unsigned VFP       = DEF_VFP,
  parameter int unsigned VSYNC     = DEF_VSYNC,
  parameter int unsigned VBP       = DEF_VBP,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [AWIDTH-1:0]  base_addr,
  input  logic [COLOR_W-1:0] fg,
  input  logic [COLOR_W-1:0] bg,
  output logic               re,
  output logic [AWIDTH-1:0]  raddr,
  input  logic [DWIDTH-1:0]  rdata,
  output logic [COLOR_W-1:0] pixel,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               frame_start
);

  localparam int unsigned HT    = HVIS + HFP + HSYNC + HBP;
  localparam int unsigned VT    = VVIS + VFP + VSYNC + VBP;
  localparam int unsigned HW    = $clog2(HT);
  localparam int unsigned VW    = $clog2(VT);
  localparam int unsigned WB    = $clog2(DWIDTH);
  localparam int unsigned WPL_L = words_per_line(HVIS, DWIDTH);

  logic [HW-1:0]      h;
  logic [VW-1:0]      v;
  logic               hs_raw, vs_raw, vis_raw;
  logic               h_last, v_vis;
  logic [AWIDTH-1:0]  line_base_q, line_base_d, raddr_q, fetch_addr;
  logic               re_q;
  logic [DWIDTH-1:0]  shift_q, shift_d;
  logic [1:0]         hs_q, vs_q, blank_q;

  vga_timing #(
    .HVIS (HVIS),
    .HFP  (HFP),
    .HSYNC(HSYNC),
    .HBP  (HBP),
    .VVIS (VVIS),
    .VFP  (VFP),
    .VSYNC(VSYNC),
    .VBP  (VBP)
  ) u_timing (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .h_o          (h),
    .v_o          (v),
    .hsync_o      (hs_raw),
    .vsync_o      (vs_raw),
    .vis_o        (vis_raw),
    .frame_start_o(frame_start)
  );

  assign h_last = (h == HW'(HT - 1));
  assign v_vis  = (v < VW'(VVIS));
  assign re     = vis_raw && (h[WB-1:0] == '0);

  // The first fetch of a frame shares the clock in which base_addr is
  // latched, so it bypasses line_base_q.
  assign fetch_addr = (frame_start ? base_addr : line_base_q) + AWIDTH'(h >> WB);
  assign raddr      = re ? fetch_addr : raddr_q;

  always_comb begin
    line_base_d = line_base_q;
    if (frame_start) begin
      line_base_d = base_addr;
    end else if (h_last && v_vis) begin
      line_base_d = line_base_q + AWIDTH'(WPL_L);
    end
    shift_d = re_q ? rdata : {shift_q[DWIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line_base_q <= '0;
      raddr_q     <= '0;
      re_q        <= 1'b0;
      shift_q     <= '0;
      hs_q        <= '0;
      vs_q        <= '0;
      blank_q     <= '1;
    end else begin
      line_base_q <= line_base_d;
      raddr_q     <= raddr;
      re_q        <= re;
      shift_q     <= shift_d;
      hs_q        <= {hs_q[0], hs_raw};
      vs_q        <= {vs_q[0], vs_raw};
      blank_q     <= {blank_q[0], ~vis_raw};
    end
  end

  assign hsync = hs_q[1] ? HSYNC_POL : ~HSYNC_POL;
  assign vsync = vs_q[1] ? VSYNC_POL : ~VSYNC_POL;
  assign blank = blank_q[1];
  assign pixel = blank_q[1] ? '0 : (shift_q[DWIDTH-1] ? fg : bg);

endmodule

// File: tb/tb_vga_scanout.sv
// Randomised bench for vga_scanout (small 40x8 raster) with a position-based
// reference model; a second instance covers inverted sync polarity.
module tb_vga_scanout;

  localparam int unsigned DW = 16, AW = 8, CW = 8;
  localparam int unsigned HVIS = 32, HFP = 2, HSYNC = 4, HBP = 2;
  localparam int unsigned VVIS = 4, VFP = 1, VSYNC = 2, VBP = 1;
  localparam int unsigned HT = HVIS + HFP + HSYNC + HBP;
  localparam int unsigned VT = VVIS + VFP + VSYNC + VBP;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic pb;
  } ent_t;
  localparam ent_t IDLE = '{hs: 1'b0, vs: 1'b0, blank: 1'b1, pb: 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] fg, bg;
  logic [DW-1:0] rdata;
  logic          re, hsync, vsync, blank, frame_start;
  logic [AW-1:0] raddr;
  logic [CW-1:0] pixel;
  logic          re_p, hsync_p, vsync_p, blank_p, frame_start_p;
  logic [AW-1:0] raddr_p;
  logic [CW-1:0] pixel_p;

  vga_scanout #(
    .DWIDTH(DW), .AWIDTH(AW), .COLOR_W(CW),
    .HVIS(HVIS), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
    .VVIS(VVIS), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr), .fg(fg), .bg(bg),
    .re(re), .raddr(raddr), .rdata(rdata), .pixel(pixel),
    .hsync(hsync), .vsync(vsync), .blank(blank), .frame_start(frame_start)
  );

  vga_scanout #(
    .DWIDTH(DW), .AWIDTH(AW), .COLOR_W(CW),
    .HVIS(HVIS), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
    .VVIS(VVIS), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_pol (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr), .fg(fg), .bg(bg),
    .re(re_p), .raddr(raddr_p), .rdata(rdata), .pixel(pixel_p),
    .hsync(hsync_p), .vsync(vsync_p), .blank(blank_p), .frame_start(frame_start_p)
  );

  // Video RAM read port: one clock of latency.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

  int unsigned n_tests = 0, n_fail = 0;

  // Reference state: raster position of the current clock plus two clocks
  // of output history.
  int unsigned mh = 0, mv = 0;
  bit          hold = 1'b1, armed = 1'b0;
  logic [7:0]  fb = '0, last_raddr = '0;
  ent_t        d1 = IDLE, d2 = IDLE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t (model h=%0d v=%0d)",
               tag, got, exp, $time, mh, mv);
    end
  endtask

  task automatic cycle(input bit rst_n);
    bit            fs, vis, rexp;
    logic [7:0]    addr, rad_exp;
    logic [DW-1:0] word;
    logic [CW-1:0] pexp;
    ent_t          e;
    reset_n = rst_n;
    @(negedge clk);
    fs = !hold && mh == 0 && mv == 0;
    if (fs) fb = base_addr;
    vis     = !hold && mh < HVIS && mv < VVIS;
    rexp    = vis && (mh % DW == 0);
    addr    = 8'(int'(fb) + 2 * mv + mh / DW);
    rad_exp = rexp ? addr : last_raddr;
    pexp    = d2.blank ? '0 : (d2.pb ? fg : bg);
    if (armed) begin
      check("frame_start", frame_start, fs);
      check("re", re, rexp);
      check("raddr", raddr, rad_exp);
      check("hsync", hsync, !d2.hs);
      check("vsync", vsync, !d2.vs);
      check("blank", blank, d2.blank);
      check("pixel", pixel, pexp);
      check("re_pol", re_p, rexp);
      check("raddr_pol", raddr_p, rad_exp);
      check("frame_start_pol", frame_start_p, fs);
      check("hsync_pol", hsync_p, d2.hs);
      check("vsync_pol", vsync_p, d2.vs);
      check("blank_pol", blank_p, d2.blank);
      check("pixel_pol", pixel_p, pexp);
    end
    if (!rst_n) begin
      armed = 1'b1; hold = 1'b1; mh = 0; mv = 0;
      d1 = IDLE; d2 = IDLE; last_raddr = '0;
    end else begin
      e = IDLE;
      if (!hold) begin
        word    = mem[addr];
        e.hs    = (mh >= HVIS + HFP) && (mh < HVIS + HFP + HSYNC);
        e.vs    = (mv >= VVIS + VFP) && (mv < VVIS + VFP + VSYNC);
        e.blank = !vis;
        e.pb    = word[DW - 1 - (mh % DW)];
      end
      d2 = d1;
      d1 = e;
      last_raddr = rad_exp;
      if (!hold) begin
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv = (mv + 1) % VT;
        end
      end
      hold = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int unsigned n);
    for (int i = 0; i < int'(n); i++) cycle(1'b1);
  endtask

  initial begin
    bit reached;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[8'h10] = 16'h8001;
    reset_n = 1'b0; base_addr = 8'h10; fg = 8'hFF; bg = 8'h00;
    @(posedge clk); #1;

    // Reset, then two frames from base 0x10 with fg/bg = FF/00.
    repeat (3) cycle(1'b0);
    run(2 * HT * VT);

    // Base near the top of the address space; mid-frame change deferred.
    base_addr = 8'hFE;
    run(HT * VT + 100);
    base_addr = 8'h40;
    run(HT * VT);

    // Reset mid-frame at (h=20, v=2) for three clocks.
    reached = 1'b0;
    for (int i = 0; i < int'(2 * HT * VT) && !reached; i++) begin
      if (mh == 20 && mv == 2 && !hold) reached = 1'b1;
      else cycle(1'b1);
    end
    check("reach_reset_point", 32'(reached), 32'd1);
    base_addr = 8'h30;
    repeat (3) cycle(1'b0);
    run(HT * VT + 50);

    // Random traffic: base changes, colour changes in vertical blanking,
    // occasional reset pulses.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(99) == 0) base_addr = 8'($urandom);
      if (!hold && (mv == 5 || mv == 6) && $urandom_range(19) == 0) begin
        fg = 8'($urandom);
        bg = 8'($urandom);
      end
      if ($urandom_range(499) == 0) repeat ($urandom_range(3, 1)) cycle(1'b0);
      else cycle(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
